// File: rtl/card_pkg.sv
// Purpose: shared types and constants for the card input conditioning path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package card_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } filt_state_t;

  localparam int CLK_PERIOD_NS = 1280;
  // 10 ms worth of 1.28 us clock periods
  localparam int FILT_10MS     = 7813;

endpackage

// File: rtl/card_sync.sv
// Purpose: plain flop-chain synchroniser for an asynchronous level input.
// Latency: SYNC_STAGES clk edges from d to q.
// Backpressure: none; free-running level path.
// Ports: clk, reset (sync active-low, loads RESET_LEVEL), d (async in), q (synchronised out).
module card_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // No logic between stages so each flop has a full period to resolve.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/card_input_filter.sv
// Purpose: synchronise and glitch-filter a raw card-edge input, with edge strobes and glitch count.
// Latency: out follows a steady raw_in after SYNC_STAGES+FILTER_CYCLES edges.
// Backpressure: none; outputs are always-valid levels/strobes.
// Ports: clk, reset (sync active-low), raw_in (async), glitch_clr (sync clear of glitch_cnt),
//        out (filtered level), rise/fall (1-cycle strobes), glitch_cnt (saturating reject count).
module card_input_filter
  import card_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = FILT_10MS,
  parameter int   CNT_W         = 13,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  input  logic       glitch_clr,
  output logic       out,
  output logic       rise,
  output logic       fall,
  output logic [7:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FILTER_CYCLES - 1);
  localparam filt_state_t      RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             s;
  filt_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, rise_nxt, fall_nxt;
  logic             glitch;
  logic [7:0]       glitch_cnt_nxt;

  card_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RST_STATE;
      cnt        <= '0;
      out        <= RESET_LEVEL;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out        <= out_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      glitch_cnt <= glitch_cnt_nxt;
    end
  end

  // cnt holds the number of consecutive opposite-level samples seen so far;
  // entering QUAL_* already accounts for the first one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch    = 1'b0;

    case (state)
      STABLE_LO: begin
        cnt_nxt = '0;
        if (s) begin
          state_nxt = QUAL_HI;
          cnt_nxt   = CNT_W'(1);
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          out_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        cnt_nxt = '0;
        if (!s) begin
          state_nxt = QUAL_LO;
          cnt_nxt   = CNT_W'(1);
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          out_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        // Recover from a corrupted state register; out is deliberately held.
        state_nxt = RST_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clear takes priority over a simultaneous glitch.
  always_comb begin
    glitch_cnt_nxt = glitch_cnt;
    if (glitch_clr) begin
      glitch_cnt_nxt = 8'd0;
    end else if (glitch && (glitch_cnt != 8'hFF)) begin
      glitch_cnt_nxt = glitch_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_card_input_filter.sv
module tb_card_input_filter;

  localparam int   SYNC   = 2;
  localparam int   FILT   = 4;
  localparam int   CW     = 3;
  localparam logic RST_LV = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_in;
  logic       glitch_clr;
  logic       out;
  logic       rise;
  logic       fall;
  logic [7:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  card_input_filter #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .CNT_W         (CW),
    .RESET_LEVEL   (RST_LV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .glitch_clr (glitch_clr),
    .out        (out),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a delay line for the synchroniser and a run-length
  // counter of samples disagreeing with the accepted level.
  bit m_q[$];
  bit m_out;
  int m_run;
  int m_gc;
  bit m_rise, m_fall;

  function automatic void model_edge(bit r, bit c, bit rs);
    bit s;
    bit g;
    m_rise = 0;
    m_fall = 0;
    if (!rs) begin
      m_q.delete();
      for (int i = 0; i < SYNC; i++) m_q.push_back(RST_LV);
      m_out = RST_LV;
      m_run = 0;
      m_gc  = 0;
      return;
    end
    s = m_q.pop_back();
    m_q.push_front(r);
    g = 0;
    if (s != m_out) begin
      m_run++;
      if (m_run == FILT) begin
        m_out = s;
        m_run = 0;
        if (s) m_rise = 1;
        else   m_fall = 1;
      end
    end else begin
      if (m_run > 0) g = 1;
      m_run = 0;
    end
    if (c) m_gc = 0;
    else if (g && m_gc < 255) m_gc++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d: got %0d, want %0d", name, step_no, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare DUT to the model.
  task automatic tick(input logic r, input logic c, input logic rs);
    raw_in     = r;
    glitch_clr = c;
    reset      = rs;
    @(posedge clk);
    model_edge(r, c, rs);
    #1;
    step_no++;
    chk("model_out",  {31'd0, out},  {31'd0, m_out});
    chk("model_rise", {31'd0, rise}, {31'd0, m_rise});
    chk("model_fall", {31'd0, fall}, {31'd0, m_fall});
    chk("model_gcnt", {24'd0, glitch_cnt}, m_gc);
  endtask

  typedef struct {
    logic       raw;
    logic       clr;
    logic       rst;
    logic       e_out;
    logic       e_rise;
    logic       e_fall;
    logic [7:0] e_gc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit saw_fall, saw_change, saw_strobe;
    int run_left;
    bit cur;

    raw_in     = 1'b1;
    glitch_clr = 1'b0;
    reset      = 1'b0;

    // Reset held with raw high, two idle low cycles, then a held rise.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].raw, tbl[i].clr, tbl[i].rst);
      chk("tbl_out",  {31'd0, out},  {31'd0, tbl[i].e_out});
      chk("tbl_rise", {31'd0, rise}, {31'd0, tbl[i].e_rise});
      chk("tbl_fall", {31'd0, fall}, {31'd0, tbl[i].e_fall});
      chk("tbl_gcnt", {24'd0, glitch_cnt}, {24'd0, tbl[i].e_gc});
    end

    // Short low pulse from stable high is rejected and counted.
    saw_fall = 0;
    tick(1'b0, 1'b0, 1'b1);
    saw_fall |= fall;
    tick(1'b0, 1'b0, 1'b1);
    saw_fall |= fall;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      saw_fall |= fall;
    end
    chk("pulse_out",  {31'd0, out}, 32'd1);
    chk("pulse_fall", {31'd0, saw_fall}, 32'd0);
    chk("pulse_gcnt", {24'd0, glitch_cnt}, 32'd1);

    // 260 rejected pulses saturate the counter.
    for (int p = 0; p < 260; p++) begin
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1);
    end
    chk("sat_gcnt", {24'd0, glitch_cnt}, 32'd255);
    chk("sat_out",  {31'd0, out}, 32'd1);

    // Clear on the very edge the next glitch is recorded.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("pre_clr_gcnt", {24'd0, glitch_cnt}, 32'd255);
    tick(1'b1, 1'b1, 1'b1);
    chk("clr_wins_gcnt", {24'd0, glitch_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);

    // Go to stable low, then reset in the middle of a rising qualification.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
    chk("low_out", {31'd0, out}, 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      chk("rstq_out",  {31'd0, out},  32'd0);
      chk("rstq_rise", {31'd0, rise}, 32'd0);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      chk("relat_out",  {31'd0, out},  (i == 6) ? 32'd1 : 32'd0);
      chk("relat_rise", {31'd0, rise}, (i == 6) ? 32'd1 : 32'd0);
    end

    // Every-cycle toggling from stable low never passes through.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
    saw_change = 0;
    saw_strobe = 0;
    for (int i = 0; i < 50; i++) begin
      tick(logic'(i % 2), 1'b0, 1'b1);
      saw_change |= out;
      saw_strobe |= rise | fall;
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      saw_change |= out;
      saw_strobe |= rise | fall;
    end
    chk("toggle_out",    {31'd0, saw_change}, 32'd0);
    chk("toggle_strobe", {31'd0, saw_strobe}, 32'd0);

    // Random run lengths around the filter threshold, with sporadic clears and resets.
    cur = 1'b0;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        cur = ~cur;
        run_left = int'($urandom_range(1, 2 * FILT + 2));
      end
      run_left--;
      tick(cur, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
